// File: rtl/busca_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
package busca_pkg;

  localparam int LARGURA_PADRAO = 16;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    DEMANDA  = 2'd1,
    PREBUSCA = 2'd2
  } estado_t;

  // Next sequential address; the add wraps naturally at 2^LARGURA_PADRAO.
  function automatic logic [LARGURA_PADRAO-1:0] proximo_endereco(
    input logic [LARGURA_PADRAO-1:0] a
  );
    return a + LARGURA_PADRAO'(1);
  endfunction

endpackage

// File: rtl/entrada_de_busca.sv
// One tag/data/valid fetch entry with write, invalidate and hit compare.
module entrada_de_busca #(
  parameter int LARGURA = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               escreve,
  input  logic               invalida,
  input  logic [LARGURA-1:0] tag_novo,
  input  logic [LARGURA-1:0] dado_novo,
  input  logic [LARGURA-1:0] endereco,
  output logic [LARGURA-1:0] tag,
  output logic [LARGURA-1:0] dado,
  output logic               valido,
  output logic               acerto
);

  // A write on the same edge as an invalidate wins: the fill is newer.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag    <= '0;
      dado   <= '0;
      valido <= 1'b0;
    end else if (escreve) begin
      tag    <= tag_novo;
      dado   <= dado_novo;
      valido <= 1'b1;
    end else if (invalida) begin
      valido <= 1'b0;
    end
  end

  assign acerto = valido && (tag == endereco);

endmodule

// File: rtl/busca_de_instrucao.sv
// Instruction fetch: current entry C, sequential prefetch entry P, one outstanding request.
// Optional BUSCA_ESTATISTICAS_EN adds saturating miss / promotion counters.
module busca_de_instrucao
  import busca_pkg::*;
#(
  parameter int LARGURA       = LARGURA_PADRAO,
  parameter int LIMITE_ESPERA = 255
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] endereco,
  output logic [LARGURA-1:0] iin,
  output logic               iin_valido,
  output logic               mem_req,
  output logic [LARGURA-1:0] mem_addr,
  input  logic               mem_ack,
  input  logic [LARGURA-1:0] mem_dado,
  output logic               erro_barramento
`ifdef BUSCA_ESTATISTICAS_EN
  ,
  output logic [LARGURA-1:0] cont_falhas,
  output logic [LARGURA-1:0] cont_prebusca
`endif
);

  localparam int LE = $clog2(LIMITE_ESPERA + 1);

  estado_t              estado;
  logic [LE-1:0]        espera;
  logic                 descarta;
  logic [LARGURA-1:0]   c_tag, c_dado, p_tag, p_dado;
  logic                 c_valido, p_valido, acerto_c, acerto_p;
  logic                 falha, promove, fill_c, fill_p, ack_ok;

  assign ack_ok  = mem_req && mem_ack;
  assign falha   = !acerto_c && !acerto_p;
  assign promove = !acerto_c && acerto_p;
  // A demand fill is kept only if the core still wants that address.
  assign fill_c  = (estado == DEMANDA) && ack_ok && (mem_addr == endereco);
  assign fill_p  = (estado == PREBUSCA) && ack_ok && !descarta && !falha;

  entrada_de_busca #(.LARGURA(LARGURA)) u_c (
    .clock(clock), .reset(reset),
    .escreve(fill_c || promove), .invalida(falha),
    .tag_novo(fill_c ? mem_addr : p_tag), .dado_novo(fill_c ? mem_dado : p_dado),
    .endereco(endereco),
    .tag(c_tag), .dado(c_dado), .valido(c_valido), .acerto(acerto_c)
  );

  entrada_de_busca #(.LARGURA(LARGURA)) u_p (
    .clock(clock), .reset(reset),
    .escreve(fill_p), .invalida(falha || promove),
    .tag_novo(mem_addr), .dado_novo(mem_dado),
    .endereco(endereco),
    .tag(p_tag), .dado(p_dado), .valido(p_valido), .acerto(acerto_p)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      estado          <= OCIOSO;
      espera          <= '0;
      descarta        <= 1'b0;
      iin             <= '0;
      iin_valido      <= 1'b0;
      mem_req         <= 1'b0;
      mem_addr        <= '0;
      erro_barramento <= 1'b0;
`ifdef BUSCA_ESTATISTICAS_EN
      cont_falhas     <= '0;
      cont_prebusca   <= '0;
`endif
    end else begin
      erro_barramento <= 1'b0;

      // A matching demand fill is presented like a hit on the same edge.
      if (acerto_c) begin
        iin        <= c_dado;
        iin_valido <= 1'b1;
      end else if (fill_c) begin
        iin        <= mem_dado;
        iin_valido <= 1'b1;
      end else begin
        iin_valido <= 1'b0;
      end

`ifdef BUSCA_ESTATISTICAS_EN
      if (promove && cont_prebusca != '1)
        cont_prebusca <= cont_prebusca + LARGURA'(1);
`endif

      case (estado)
        OCIOSO: begin
          espera <= '0;
          if (falha) begin
            mem_req  <= 1'b1;
            mem_addr <= endereco;
            estado   <= DEMANDA;
`ifdef BUSCA_ESTATISTICAS_EN
            if (cont_falhas != '1)
              cont_falhas <= cont_falhas + LARGURA'(1);
`endif
          end else if (c_valido && !p_valido) begin
            mem_req  <= 1'b1;
            mem_addr <= LARGURA'(proximo_endereco(LARGURA_PADRAO'(c_tag)));
            descarta <= 1'b0;
            estado   <= PREBUSCA;
          end
        end
        DEMANDA, PREBUSCA: begin
          // A flush while prefetching makes the returning word stale.
          if (estado == PREBUSCA && falha)
            descarta <= 1'b1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            espera  <= '0;
            estado  <= OCIOSO;
          end else if (espera == LE'(LIMITE_ESPERA - 1)) begin
            erro_barramento <= 1'b1;
            mem_req         <= 1'b0;
            espera          <= '0;
            estado          <= OCIOSO;
          end else begin
            espera <= espera + LE'(1);
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_busca_de_instrucao.sv
// Scoreboard bench: stimulus queues expected requests/words, a negedge monitor checks them.
module tb_busca_de_instrucao;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] endereco;
  logic [15:0] iin;
  logic        iin_valido;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_dado = '0;
  logic        erro_barramento;
`ifdef BUSCA_ESTATISTICAS_EN
  logic [15:0] cont_falhas, cont_prebusca;
`endif

  always #5 clock = ~clock;

  busca_de_instrucao #(.LARGURA(16), .LIMITE_ESPERA(4)) dut (
    .clock(clock), .reset(reset), .endereco(endereco),
    .iin(iin), .iin_valido(iin_valido),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_dado(mem_dado),
    .erro_barramento(erro_barramento)
`ifdef BUSCA_ESTATISTICAS_EN
    , .cont_falhas(cont_falhas), .cont_prebusca(cont_prebusca)
`endif
  );

  int total = 0;
  int bad   = 0;
  int n_erro = 0;
  logic [15:0] q_req[$];
  logic [15:0] q_iin[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, want);
    end
  endtask

  function automatic logic [15:0] palavra(input logic [15:0] a);
    return (a == 16'h0000) ? 16'h1234 : (a ^ 16'h5A5A);
  endfunction

  // Memory model: acks after the request has been seen on `latencia` negedges.
  logic mudo = 1'b0;
  int   latencia = 2;
  int   cnt_mem = 0;
  always @(negedge clock) begin
    if (mem_req && !mudo) begin
      cnt_mem = cnt_mem + 1;
      if (cnt_mem >= latencia) begin
        mem_ack  = 1'b1;
        mem_dado = palavra(mem_addr);
        cnt_mem  = 0;
      end else begin
        mem_ack = 1'b0;
      end
    end else begin
      mem_ack = 1'b0;
      cnt_mem = 0;
    end
  end

  // Monitor: each new request and each newly valid word is popped and compared.
  logic        req_ant = 1'b0, val_ant = 1'b0;
  logic [15:0] addr_ant = '0;
  logic [15:0] esperado;
  always @(negedge clock) begin
    if (mem_req && !req_ant) begin
      if (q_req.size() == 0) chk("req_inesperado", {16'h0, mem_addr}, 32'hFFFF_FFFF);
      else begin
        esperado = q_req.pop_front();
        chk("mem_addr", {16'h0, mem_addr}, {16'h0, esperado});
      end
    end else if (mem_req && req_ant) begin
      chk("mem_addr_estavel", {16'h0, mem_addr}, {16'h0, addr_ant});
    end
    if (iin_valido && !val_ant) begin
      if (q_iin.size() == 0) chk("iin_inesperado", {16'h0, iin}, 32'hFFFF_FFFF);
      else begin
        esperado = q_iin.pop_front();
        chk("iin", {16'h0, iin}, {16'h0, esperado});
      end
    end
    if (erro_barramento) n_erro++;
    req_ant  = mem_req;
    val_ant  = iin_valido;
    addr_ant = mem_addr;
  end

  task automatic ciclo();
    @(negedge clock);
    #1;
  endtask

  task automatic espera_ack(input string nm);
    int n;
    n = 0;
    ciclo();
    while (!mem_ack && n < 20) begin
      ciclo();
      n++;
    end
    chk(nm, {31'h0, mem_ack}, 32'h1);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_iin"}, {16'h0, iin}, 32'h0);
    chk({nm, "_valido"}, {31'h0, iin_valido}, 32'h0);
    chk({nm, "_req"}, {31'h0, mem_req}, 32'h0);
    chk({nm, "_addr"}, {16'h0, mem_addr}, 32'h0);
    chk({nm, "_erro"}, {31'h0, erro_barramento}, 32'h0);
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    endereco = 16'h0000;
    repeat (2) ciclo();
    chk_reset("reset");

    // Cold miss on 0x0000, then sequential prefetch of 0x0001.
    q_req.push_back(16'h0000); q_iin.push_back(16'h1234); q_req.push_back(16'h0001);
    reset = 1'b0;
    espera_ack("ack_demanda0");
    ciclo();
    chk("iin_pos_ack_valido", {31'h0, iin_valido}, 32'h1);
    chk("iin_pos_ack", {16'h0, iin}, 32'h1234);
    ciclo();
    chk("prebusca1_req", {15'h0, mem_req, mem_addr}, {15'h0, 1'b1, 16'h0001});

    // Branch while the prefetch is in flight; its data must be dropped.
    q_req.push_back(16'h0040); q_iin.push_back(16'h5A1A); q_req.push_back(16'h0041);
    endereco = 16'h0040;
    ciclo();
    chk("prebusca_congelada", {15'h0, mem_req, mem_addr}, {15'h0, 1'b1, 16'h0001});
    chk("desvio_valido", {31'h0, iin_valido}, 32'h0);
    ciclo();
    chk("req_cai_no_ack", {31'h0, mem_req}, 32'h0);
    ciclo();
    chk("demanda_desvio", {15'h0, mem_req, mem_addr}, {15'h0, 1'b1, 16'h0040});
    espera_ack("ack_demanda40");
    espera_ack("ack_prebusca41");
    ciclo();

    // Sequential step 0x40 -> 0x41: promotion, one stall cycle, no demand.
    q_iin.push_back(16'h5A1B); q_req.push_back(16'h0042);
    endereco = 16'h0041;
    ciclo();
    chk("promocao_bolha", {31'h0, iin_valido}, 32'h0);
    ciclo();
    chk("promocao_valido", {31'h0, iin_valido}, 32'h1);
    chk("promocao_iin", {16'h0, iin}, 32'h5A1B);
`ifdef BUSCA_ESTATISTICAS_EN
    chk("cont_falhas", {16'h0, cont_falhas}, 32'd2);
    chk("cont_prebusca", {16'h0, cont_prebusca}, 32'd1);
`endif
    espera_ack("ack_prebusca42");
    ciclo();

    // Wrap: C.tag=0xFFFF prefetches 0x0000.
    q_req.push_back(16'hFFFF); q_iin.push_back(16'hA5A5); q_req.push_back(16'h0000);
    endereco = 16'hFFFF;
    espera_ack("ack_demandaFFFF");
    espera_ack("ack_prebusca0000");
    ciclo();
    q_iin.push_back(16'h1234); q_req.push_back(16'h0001);
    endereco = 16'h0000;
    espera_ack("ack_prebusca0001");
    ciclo();

    // Timeout: memory silent, error pulse on the 4th wait cycle, then retry.
    q_req.push_back(16'h0100); q_req.push_back(16'h0100);
    q_iin.push_back(16'h5B5A); q_req.push_back(16'h0101);
    mudo = 1'b1;
    endereco = 16'h0100;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      ciclo();
      if (erro_barramento) break;
      if (mem_req) n++;
    end
    chk("erro_pulso", {31'h0, erro_barramento}, 32'h1);
    chk("ciclos_espera", n, 32'd4);
    chk("timeout_req_baixo", {31'h0, mem_req}, 32'h0);
    ciclo();
    chk("reemissao", {15'h0, mem_req, mem_addr}, {15'h0, 1'b1, 16'h0100});
    chk("erro_um_ciclo", {31'h0, erro_barramento}, 32'h0);
    mudo = 1'b0;
    espera_ack("ack_reemissao");
    chk("n_erro", n_erro, 32'd1);
    espera_ack("ack_prebusca101");

    // Reset in the same cycle as an ack: data dropped, C invalid afterwards.
    q_req.push_back(16'h0100); q_iin.push_back(16'h5B5A); q_req.push_back(16'h0101);
    reset = 1'b1;
    ciclo();
    chk_reset("reset_com_ack");
    reset = 1'b0;
    espera_ack("ack_pos_reset");
    espera_ack("ack_prebusca_pos_reset");
    repeat (3) ciclo();
    chk("fila_req_vazia", q_req.size(), 32'd0);
    chk("fila_iin_vazia", q_iin.size(), 32'd0);
    chk("n_erro_final", n_erro, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
